// File: rtl/alu_cond_writeback_if.sv
// Bundle between the ALU result stage, this writeback unit and the register-file write port.
// The slave view is the writeback unit; the master view is whoever drives ALU ops and accepts writes.
interface alu_cond_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_nzcv;
    logic        in_setflags;
    logic [3:0]  in_cond;
    logic [3:0]  in_rd;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;

    modport slave (
        input  in_valid, in_result, in_nzcv, in_setflags, in_cond, in_rd, wb_ready,
        output in_ready, wb_valid, wb_rd, wb_data
    );

    modport master (
        output in_valid, in_result, in_nzcv, in_setflags, in_cond, in_rd, wb_ready,
        input  in_ready, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/alu_cond_writeback.sv
// Conditional-execution writeback: evaluates each ALU op's condition code against the NZCV
// register, updates flags, and queues passing results for the register-file write port.
module alu_cond_writeback #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cond_writeback_if.slave  bus,
    output logic [3:0]           flags,
    output logic [CNT_W-1:0]     exec_cnt,
    output logic [CNT_W-1:0]     skip_cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [35:0]      mem_reg [DEPTH];
    logic [3:0]       flags_reg;
    logic [CNT_W-1:0] exec_cnt_reg;
    logic [CNT_W-1:0] skip_cnt_reg;

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;
    logic accept, push, skip, pop;

    assign flag_n = flags_reg[3];
    assign flag_z = flags_reg[2];
    assign flag_c = flags_reg[1];
    assign flag_v = flags_reg[0];

    // Evaluated against the registered flags; a preceding setflags op has already landed there.
    always_comb begin
        cond_pass = 1'b1;
        case (bus.in_cond)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            default: cond_pass = 1'b1;
        endcase
    end

    // in_ready depends only on the registered count, so a same-cycle pop never opens a full FIFO.
    assign bus.in_ready = (count_reg != FULL_CNT);
    assign bus.wb_valid = (count_reg != '0);
    assign bus.wb_rd    = mem_reg[rd_ptr_reg][35:32];
    assign bus.wb_data  = mem_reg[rd_ptr_reg][31:0];

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && cond_pass;
    assign skip   = accept && !cond_pass;
    assign pop    = bus.wb_valid && bus.wb_ready;

    assign flags    = flags_reg;
    assign exec_cnt = exec_cnt_reg;
    assign skip_cnt = skip_cnt_reg;

    // Storage is cleared on reset so the head outputs are defined even before the first write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push) begin
            mem_reg[wr_ptr_reg] <= {bus.in_rd, bus.in_result};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg    <= '0;
            exec_cnt_reg <= '0;
            skip_cnt_reg <= '0;
        end else begin
            if (push && bus.in_setflags) begin
                flags_reg <= bus.in_nzcv;
            end
            if (push && (exec_cnt_reg != '1)) begin
                exec_cnt_reg <= exec_cnt_reg + CNT_W'(1);
            end
            if (skip && (skip_cnt_reg != '1)) begin
                skip_cnt_reg <= skip_cnt_reg + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_alu_cond_writeback.sv
// Scoreboard bench for alu_cond_writeback: expected writes are queued at accept time and
// compared when the register-file port pops them; flags and counters are tracked by a model.
module tb_alu_cond_writeback;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int BUDGET = 50;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       flags;
    logic [CNT_W-1:0] exec_cnt;
    logic [CNT_W-1:0] skip_cnt;

    alu_cond_writeback_if bus();

    alu_cond_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .flags    (flags),
        .exec_cnt (exec_cnt),
        .skip_cnt (skip_cnt)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [35:0] exp_q[$];
    logic [3:0]  m_flags = '0;
    int          m_exec = 0;
    int          m_skip = 0;
    int          sat_max = (1 << CNT_W) - 1;

    task automatic check_eq(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Condition table written as a base predicate per pair, odd codes invert it.
    function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = ~(n ^ v);
            3'd6: base = ~z & ~(n ^ v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    // Monitor on the falling edge: inputs and outputs are both stable for the coming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_flags = '0;
            m_exec  = 0;
            m_skip  = 0;
        end else begin
            logic [35:0] e;
            check_eq("flags", 36'(flags), 36'(m_flags));
            check_eq("exec_cnt", 36'(exec_cnt), 36'(m_exec));
            check_eq("skip_cnt", 36'(skip_cnt), 36'(m_skip));
            check_eq("wb_valid", 36'(bus.wb_valid), 36'(exp_q.size() != 0));
            check_eq("in_ready", 36'(bus.in_ready), 36'(exp_q.size() < DEPTH));
            if (bus.wb_valid && bus.wb_ready) begin
                check_eq("wb_expected", 36'(exp_q.size() != 0), 36'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("wb_rd", 36'(bus.wb_rd), 36'(e[35:32]));
                    check_eq("wb_data", 36'(bus.wb_data), 36'(e[31:0]));
                    $display("[TB] wb rd=%0d data=%08h", bus.wb_rd, bus.wb_data);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (model_pass(bus.in_cond, m_flags)) begin
                    exp_q.push_back({bus.in_rd, bus.in_result});
                    if (m_exec < sat_max) m_exec++;
                    if (bus.in_setflags) m_flags = bus.in_nzcv;
                end else begin
                    if (m_skip < sat_max) m_skip++;
                end
            end
        end
    end

    // All driving happens 1 time unit after the rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] c, input logic sf, input logic [3:0] nz,
                        input logic [3:0] rd, input logic [31:0] res);
        int n = 0;
        bus.in_valid    = 1'b1;
        bus.in_cond     = c;
        bus.in_setflags = sf;
        bus.in_nzcv     = nz;
        bus.in_rd       = rd;
        bus.in_result   = res;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n >= BUDGET) break;
        end
        if (n >= BUDGET) check_eq("send_timeout", 36'(n < BUDGET), 36'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_cond     = '0;
        bus.in_setflags = 1'b0;
        bus.in_nzcv     = '0;
        bus.in_rd       = '0;
        bus.in_result   = '0;
        bus.wb_ready    = 1'b0;
        cyc(3);
        rst_n = 1'b1;

        // Reset state
        check_eq("rst_flags", 36'(flags), 36'(0));
        check_eq("rst_wb_valid", 36'(bus.wb_valid), 36'(0));
        check_eq("rst_wb_rd", 36'(bus.wb_rd), 36'(0));
        check_eq("rst_wb_data", 36'(bus.wb_data), 36'(0));
        check_eq("rst_in_ready", 36'(bus.in_ready), 36'(1));
        check_eq("rst_exec", 36'(exec_cnt), 36'(0));

        // Z/EQ chain, back-to-back
        bus.wb_ready = 1'b1;
        send(4'hE, 1'b1, 4'b0100, 4'd1, 32'd0);
        send(4'h0, 1'b0, 4'b0000, 4'd2, 32'd5);
        send(4'h1, 1'b0, 4'b0000, 4'd3, 32'd7);
        cyc(3);
        check_eq("t2_flags", 36'(flags), 36'(4'b0100));
        check_eq("t2_exec", 36'(exec_cnt), 36'(2));
        check_eq("t2_skip", 36'(skip_cnt), 36'(1));

        // Signed compares
        send(4'hE, 1'b1, 4'b1000, 4'd4, 32'h11);
        send(4'hB, 1'b0, 4'b0000, 4'd5, 32'h22);
        send(4'hA, 1'b0, 4'b0000, 4'd6, 32'h33);
        send(4'hE, 1'b1, 4'b1001, 4'd7, 32'h44);
        send(4'hC, 1'b0, 4'b0000, 4'd8, 32'h55);
        send(4'hE, 1'b1, 4'b1101, 4'd9, 32'h66);
        send(4'hC, 1'b0, 4'b0000, 4'd10, 32'h77);
        cyc(3);
        check_eq("t3_exec", 36'(exec_cnt), 36'(7));
        check_eq("t3_skip", 36'(skip_cnt), 36'(3));

        // Full sweep of conditions against every flag value
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                send(4'hE, 1'b1, 4'(f), 4'($urandom_range(15)), $urandom);
                send(4'(c), 1'b0, 4'(~f), 4'($urandom_range(15)), $urandom);
            end
        end
        cyc(4);

        // Backpressure: fifth op held until the port drains
        bus.wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'hE, 1'b0, 4'b0000, 4'(i), 32'hA000_0000 + 32'(i));
        check_eq("t4_full", 36'(bus.in_ready), 36'(0));
        fork
            send(4'hE, 1'b0, 4'b0000, 4'd4, 32'hA000_0004);
            begin
                cyc(3);
                check_eq("t4_held_ready", 36'(bus.in_ready), 36'(0));
                check_eq("t4_held_rd", 36'(bus.wb_rd), 36'(0));
                check_eq("t4_held_data", 36'(bus.wb_data), 36'(32'hA000_0000));
                bus.wb_ready = 1'b1;
            end
        join
        cyc(8);
        check_eq("t4_drained", 36'(exp_q.size()), 36'(0));

        // Full FIFO with simultaneous pop and push attempt
        bus.wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'hE, 1'b0, 4'b0000, 4'(8 + i), 32'hB000_0000 + 32'(i));
        fork
            send(4'hE, 1'b0, 4'b0000, 4'd12, 32'hB000_0004);
            begin
                bus.wb_ready = 1'b1;
                cyc(1);
                bus.wb_ready = 1'b0;
                check_eq("t5_ready_after_pop", 36'(bus.in_ready), 36'(1));
                check_eq("t5_no_push", 36'(exp_q.size()), 36'(3));
            end
        join
        bus.wb_ready = 1'b1;
        cyc(8);

        // Asynchronous reset in the middle of pending writes
        bus.wb_ready = 1'b0;
        send(4'hE, 1'b1, 4'b1111, 4'd1, 32'hC0DE_0001);
        send(4'hE, 1'b1, 4'b1111, 4'd2, 32'hC0DE_0002);
        cyc(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t1_flags", 36'(flags), 36'(0));
        check_eq("t1_wb_valid", 36'(bus.wb_valid), 36'(0));
        check_eq("t1_in_ready", 36'(bus.in_ready), 36'(1));
        check_eq("t1_exec", 36'(exec_cnt), 36'(0));
        check_eq("t1_skip", 36'(skip_cnt), 36'(0));
        check_eq("t1_wb_data", 36'(bus.wb_data), 36'(0));
        cyc(2);
        rst_n = 1'b1;
        bus.wb_ready = 1'b1;

        // Saturation of both counters
        for (int i = 0; i < (1 << CNT_W) + 3; i++) send(4'hE, 1'b0, 4'b0000, 4'(i), 32'(i));
        cyc(2);
        check_eq("t6_exec_sat", 36'(exec_cnt), 36'(15));
        for (int i = 0; i < (1 << CNT_W) + 2; i++) send(4'h0, 1'b0, 4'b0000, 4'(i), 32'(i));
        cyc(2);
        check_eq("t6_skip_sat", 36'(skip_cnt), 36'(15));
        check_eq("t6_exec_hold", 36'(exec_cnt), 36'(15));
        cyc(6);
        check_eq("end_drained", 36'(exp_q.size()), 36'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
